// File: rtl/seg_display_drv_if.sv
// Result handshake between the ALU and the display driver.
//   value : W-bit two's-complement result from the ALU
//   valid : one-cycle strobe, value is new
//   busy  : driver is converting; valid is ignored while high
// master = producer (ALU side), slave = seg_display_drv.
interface seg_display_drv_if #(
  parameter int unsigned W = 8
);
  logic [W-1:0] value;
  logic         valid;
  logic         busy;

  modport master (output value, output valid, input busy);
  modport slave  (input value, input valid, output busy);
endinterface

// File: rtl/seg_display_drv.sv
// Display output stage: converts the signed ALU result to decimal with a
// sequential double-dabble engine and scans it onto a 4-digit multiplexed
// 7-segment display (digit 3 carries the minus sign).
// Ports:
//   clk      : system clock, rising edge
//   rst      : asynchronous active-high reset
//   bus      : value/valid in, busy out (slave modport)
//   anodes   : active-low digit enables, anodes[0] = rightmost digit
//   segments : active-low {dp,g,f,e,d,c,b,a}, dp always off
module seg_display_drv #(
  parameter int unsigned W           = 8,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  seg_display_drv_if.slave      bus,
  output logic [3:0]            anodes,
  output logic [7:0]            segments
);

  localparam int unsigned IW  = $clog2(W + 1);
  localparam int unsigned RW  = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned BW  = 12;
  localparam int unsigned SHW = BW + W;

  typedef enum logic [1:0] {IDLE, CONV, DONE} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    mag, mag_nxt;
  logic            neg, neg_nxt;
  logic [BW-1:0]   bcd, bcd_nxt, bcd_adj;
  logic [IW-1:0]   iter, iter_nxt;
  logic [BW-1:0]   disp_bcd, disp_bcd_nxt;
  logic            disp_neg, disp_neg_nxt;
  logic            busy_q, busy_nxt;
  logic [SHW-1:0]  dd_shift;

  logic [RW-1:0]   ref_cnt;
  logic [1:0]      dig_idx;
  logic [3:0]      anodes_nxt;
  logic [7:0]      segments_nxt;

  assign bus.busy = busy_q;

  function automatic logic [7:0] seg_code(input logic [3:0] d);
    case (d)
      4'd0:    seg_code = 8'hC0;
      4'd1:    seg_code = 8'hF9;
      4'd2:    seg_code = 8'hA4;
      4'd3:    seg_code = 8'hB0;
      4'd4:    seg_code = 8'h99;
      4'd5:    seg_code = 8'h92;
      4'd6:    seg_code = 8'h82;
      4'd7:    seg_code = 8'hF8;
      4'd8:    seg_code = 8'h80;
      4'd9:    seg_code = 8'h90;
      default: seg_code = 8'hFF;
    endcase
  endfunction

  // Double-dabble correction: add 3 to every nibble >= 5 before shifting.
  always_comb begin
    bcd_adj = bcd;
    for (int n = 0; n < 3; n++) begin
      if (bcd[n*4 +: 4] >= 4'd5) bcd_adj[n*4 +: 4] = bcd[n*4 +: 4] + 4'd3;
    end
    dd_shift = {bcd_adj, mag} << 1;
  end

  // FSM state and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      mag      <= '0;
      neg      <= 1'b0;
      bcd      <= '0;
      iter     <= '0;
      disp_bcd <= '0;
      disp_neg <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_nxt;
      mag      <= mag_nxt;
      neg      <= neg_nxt;
      bcd      <= bcd_nxt;
      iter     <= iter_nxt;
      disp_bcd <= disp_bcd_nxt;
      disp_neg <= disp_neg_nxt;
      busy_q   <= busy_nxt;
    end
  end

  // Next-state and datapath updates.
  always_comb begin
    state_nxt    = state;
    mag_nxt      = mag;
    neg_nxt      = neg;
    bcd_nxt      = bcd;
    iter_nxt     = iter;
    disp_bcd_nxt = disp_bcd;
    disp_neg_nxt = disp_neg;
    case (state)
      IDLE: begin
        // busy_q is still high for the one IDLE cycle after DONE.
        if (bus.valid && !busy_q) begin
          neg_nxt   = bus.value[W-1];
          // W-bit negate: the most negative input maps to 2^(W-1).
          mag_nxt   = bus.value[W-1] ? W'(-bus.value) : bus.value;
          bcd_nxt   = '0;
          iter_nxt  = '0;
          state_nxt = CONV;
        end
      end
      CONV: begin
        bcd_nxt  = dd_shift[SHW-1:W];
        mag_nxt  = dd_shift[W-1:0];
        iter_nxt = iter + IW'(1);
        if (iter == IW'(W - 1)) state_nxt = DONE;
      end
      DONE: begin
        disp_bcd_nxt = bcd;
        disp_neg_nxt = neg;
        state_nxt    = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
    busy_nxt = (state != IDLE) || (state_nxt != IDLE);
  end

  // Free-running digit scan.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ref_cnt <= '0;
      dig_idx <= 2'd0;
    end else if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
      ref_cnt <= '0;
      dig_idx <= dig_idx + 2'd1;
    end else begin
      ref_cnt <= ref_cnt + RW'(1);
    end
  end

  // Digit content with leading-zero blanking.
  always_comb begin
    anodes_nxt   = ~(4'b0001 << dig_idx);
    segments_nxt = 8'hFF;
    case (dig_idx)
      2'd0: segments_nxt = seg_code(disp_bcd[3:0]);
      2'd1: segments_nxt = (disp_bcd[11:4] == 8'd0) ? 8'hFF : seg_code(disp_bcd[7:4]);
      2'd2: segments_nxt = (disp_bcd[11:8] == 4'd0) ? 8'hFF : seg_code(disp_bcd[11:8]);
      2'd3: segments_nxt = disp_neg ? 8'hBF : 8'hFF;
      default: segments_nxt = 8'hFF;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      anodes   <= 4'b1111;
      segments <= 8'hFF;
    end else begin
      anodes   <= anodes_nxt;
      segments <= segments_nxt;
    end
  end

endmodule
